// File: rtl/matrix_keypad_scanner.sv
// rtl/matrix_keypad_scanner.sv - ROWS x COLS keypad scanner: column drive, debounce, ghost rejection, event register
// Define KEYPAD_AUTOREPEAT_EN to build press auto-repeat while a key is held.
module matrix_keypad_scanner #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100,
    localparam int CW         = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   key_code,
    output logic            key_press,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            overflow
);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int HW  = $clog2(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
`else
    // Repeat timing is meaningless without auto-repeat; referenced here only so it is not dangling.
    localparam int DBW = $clog2(DEBOUNCE + 1) + 0 * (REPEAT_DLY + REPEAT_RATE);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

    state_t          state, state_n;
    logic [ROWS-1:0] row_s1, row_s2;
    logic [DW-1:0]   dwell;
    logic [CLW-1:0]  c, c_n;
    logic [RW-1:0]   r, r_n, samp_idx;
    logic [ROWS-1:0] pat, pat_n;
    logic [DBW-1:0]  cnt, cnt_n, cnt_inc;
    logic            tick, samp_one, emit, emit_press;
    logic [CW-1:0]   ev_code;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [HW-1:0]   hold, hold_n, hold_inc;
    logic            rpt, rpt_n;

    assign hold_inc = hold + 1'b1;
`endif

    assign tick     = (dwell == DW'(SCAN_DIV - 1));
    assign samp_one = (row_s2 != '0) && ((row_s2 & (row_s2 - 1'b1)) == '0);
    assign cnt_inc  = cnt + 1'b1;
    assign ev_code  = CW'(r) * CW'(COLS) + CW'(c);
    assign col      = (!en || state == ST_IDLE) ? '1 : (COLS'(1) << c);

    always_comb begin
        samp_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (row_s2[i]) samp_idx = RW'(i);
    end

    always_comb begin
        state_n    = state;
        c_n        = c;
        r_n        = r;
        pat_n      = pat;
        cnt_n      = cnt;
        emit       = 1'b0;
        emit_press = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_n     = hold;
        rpt_n      = rpt;
`endif
        if (!en) begin
            state_n = ST_IDLE;
        end else if (tick) begin
            case (state)
                ST_IDLE: if (row_s2 != '0) begin
                    state_n = ST_SCAN;
                    c_n     = '0;
                end
                ST_SCAN: if (samp_one) begin
                    state_n = ST_DEBOUNCE;
                    r_n     = samp_idx;
                    pat_n   = row_s2;
                    cnt_n   = '0;
                end else if (c == CLW'(COLS - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    c_n = c + 1'b1;
                end
                ST_DEBOUNCE: if (row_s2 != pat) begin
                    state_n = ST_IDLE;
                end else if (cnt_inc == DBW'(DEBOUNCE)) begin
                    emit       = 1'b1;
                    emit_press = 1'b1;
                    state_n    = ST_HELD;
                    cnt_n      = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    hold_n     = '0;
                    rpt_n      = 1'b0;
`endif
                end else begin
                    cnt_n = cnt_inc;
                end
                ST_HELD: if (!row_s2[r]) begin
                    if (cnt_inc == DBW'(DEBOUNCE)) begin
                        emit    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    cnt_n = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    // First repeat after REPEAT_DLY held samples, then every REPEAT_RATE.
                    if (hold_inc == (rpt ? HW'(REPEAT_RATE) : HW'(REPEAT_DLY))) begin
                        emit       = 1'b1;
                        emit_press = 1'b1;
                        hold_n     = '0;
                        rpt_n      = 1'b1;
                    end else begin
                        hold_n = hold_inc;
                    end
`endif
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_s1    <= '0;
            row_s2    <= '0;
            dwell     <= '0;
            c         <= '0;
            r         <= '0;
            pat       <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_press <= 1'b0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold      <= '0;
            rpt       <= 1'b0;
`endif
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            state  <= state_n;
            c      <= c_n;
            r      <= r_n;
            pat    <= pat_n;
            cnt    <= cnt_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold   <= hold_n;
            rpt    <= rpt_n;
`endif
            dwell  <= (state_n != state || tick) ? '0 : dwell + 1'b1;
            if (emit && (!key_valid || key_ready)) begin
                key_valid <= 1'b1;
                key_code  <= ev_code;
                key_press <= emit_press;
            end else begin
                if (emit) overflow <= 1'b1;
                if (key_ready) key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb/tb_matrix_keypad_scanner.sv - self-checking bench for matrix_keypad_scanner with a key-matrix model
module tb_matrix_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, CW = 4;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          press;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst, en, key_ready;
    logic [ROWS-1:0] row, glitch;
    logic [COLS-1:0] col;
    logic [CW-1:0]   key_code;
    logic            key_press, key_valid, overflow;
    logic [ROWS*COLS-1:0] keys;

    ev_t obs[$];
    ev_t exp_q[$];
    int  tests_run, tests_failed;

    matrix_keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
        .REPEAT_DLY(3), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
        .key_code(key_code), .key_press(key_press), .key_valid(key_valid),
        .key_ready(key_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) shorts column c onto row r; glitch adds spurious row bits.
    always_comb begin
        row = glitch;
        for (int rr = 0; rr < ROWS; rr++)
            if ((keys[rr*COLS +: COLS] & col) != '0) row[rr] = 1'b1;
    end

    always @(negedge clk)
        if (!rst && key_valid && key_ready) obs.push_back(ev_t'{code: key_code, press: key_press});

    task automatic wait_col(input logic [COLS-1:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (col === want) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL reset_col: got %b want 1111", col); end
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        tests_run++; if (key_code !== 4'd0) begin tests_failed++; $display("FAIL reset_code: got %0d want 0", key_code); end
        tests_run++; if (key_press !== 1'b0) begin tests_failed++; $display("FAIL reset_press: got %b want 0", key_press); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_press_release();
        obs.delete(); exp_q.delete();
        exp_q.push_back(ev_t'{code: 4'd9, press: 1'b1});
        exp_q.push_back(ev_t'{code: 4'd9, press: 1'b0});
        keys[2*COLS + 1] = 1'b1;
        repeat (80) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (obs.size() != exp_q.size()) begin tests_failed++; $display("FAIL press_release_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL press_release_ev%0d: got code=%0d press=%b want code=%0d press=%b", i, obs[i].code, obs[i].press, exp_q[i].code, exp_q[i].press);
            end
        end
    endtask

    task automatic test_glitch();
        bit ok;
        obs.delete();
        keys[2*COLS + 1] = 1'b1;
        wait_col(4'b0010, 100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL glitch_scan_col: got %b want 0010 (timeout)", col); end
        repeat (4) @(posedge clk);
        @(negedge clk); glitch = 4'b0001;
        repeat (4) @(posedge clk);
        @(negedge clk); glitch = 4'b0000;
        repeat (4) @(posedge clk);
        @(negedge clk); keys = '0;
        repeat (40) @(negedge clk);
        tests_run++; if (obs.size() != 0) begin tests_failed++; $display("FAIL glitch_events: got %0d want 0", obs.size()); end
        tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL glitch_idle_col: got %b want 1111", col); end
    endtask

    task automatic test_ghost();
        obs.delete(); exp_q.delete();
        exp_q.push_back(ev_t'{code: 4'd14, press: 1'b1});
        exp_q.push_back(ev_t'{code: 4'd14, press: 1'b0});
        keys[0*COLS + 0] = 1'b1;
        keys[1*COLS + 0] = 1'b1;
        keys[3*COLS + 2] = 1'b1;
        repeat (100) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (obs.size() != exp_q.size()) begin tests_failed++; $display("FAIL ghost_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL ghost_ev%0d: got code=%0d press=%b want code=%0d press=%b", i, obs[i].code, obs[i].press, exp_q[i].code, exp_q[i].press);
            end
        end
    endtask

    task automatic test_overflow();
        obs.delete();
        key_ready = 1'b0;
        keys[1*COLS + 1] = 1'b1;
        repeat (80) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        tests_run++; if (key_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_valid: got %b want 1", key_valid); end
        tests_run++; if (key_code !== 4'd5) begin tests_failed++; $display("FAIL ovf_code: got %0d want 5", key_code); end
        tests_run++; if (key_press !== 1'b1) begin tests_failed++; $display("FAIL ovf_press: got %b want 1", key_press); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        @(posedge clk); #1 key_ready = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++; if (obs.size() != 1) begin tests_failed++; $display("FAIL ovf_drained: got %0d events want 1", obs.size()); end
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_valid_clear: got %b want 0", key_valid); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_rst_in_held();
        bit ok;
        @(negedge clk); key_ready = 1'b0;
        keys[1*COLS + 2] = 1'b1;
        wait_valid(100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_press_seen: got valid=%b want 1 (timeout)", key_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL rst_col: got %b want 1111", col); end
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        key_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_disable();
        obs.delete();
        @(negedge clk); en = 1'b0;
        keys[2*COLS + 2] = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++; if (obs.size() != 0) begin tests_failed++; $display("FAIL disable_events: got %0d want 0", obs.size()); end
        tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL disable_col: got %b want 1111", col); end
        keys = '0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int rr, cc;
        obs.delete(); exp_q.delete();
        for (int n = 0; n < 8; n++) begin
            rr = $urandom_range(0, ROWS - 1);
            cc = $urandom_range(0, COLS - 1);
            exp_q.push_back(ev_t'{code: CW'(rr * COLS + cc), press: 1'b1});
            exp_q.push_back(ev_t'{code: CW'(rr * COLS + cc), press: 1'b0});
            keys[rr*COLS + cc] = 1'b1;
            repeat ($urandom_range(60, 120)) @(negedge clk);
            keys = '0;
            repeat ($urandom_range(40, 60)) @(negedge clk);
        end
        tests_run++;
        if (obs.size() != exp_q.size()) begin tests_failed++; $display("FAIL random_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_ev%0d: got code=%0d press=%b want code=%0d press=%b", i, obs[i].code, obs[i].press, exp_q[i].code, exp_q[i].press);
            end
        end
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        bit ok;
        obs.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(ev_t'{code: 4'd0, press: 1'b1});
        exp_q.push_back(ev_t'{code: 4'd0, press: 1'b0});
        keys[0] = 1'b1;
        wait_valid(100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL repeat_press_seen: got valid=%b want 1 (timeout)", key_valid); end
        repeat (36) @(posedge clk);
        @(negedge clk); keys = '0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (obs.size() != exp_q.size()) begin tests_failed++; $display("FAIL repeat_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL repeat_ev%0d: got code=%0d press=%b want code=%0d press=%b", i, obs[i].code, obs[i].press, exp_q[i].code, exp_q[i].press);
            end
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        en           = 1'b1;
        key_ready    = 1'b1;
        keys         = '0;
        glitch       = '0;
        test_reset();
        test_press_release();
        test_glitch();
        test_ghost();
        test_overflow();
        test_rst_in_held();
        test_disable();
        test_random();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
